cpu_multicycle: RTL
===================

# cpu_multicycle

Parametrised multi-cycle successor to the team's single-cycle 8-bit core. It executes the same 32-bit instruction format with generic data width and register count. A FETCH/EXEC/MEM state machine replaces the single-cycle PC-stall scheme, with explicit request/busywait handshakes to separate instruction and data memories. It adds BNE and defined NOP behaviour for unknown opcodes, and sits between the instruction cache and the data cache in the top-level CPU wrapper.

## Interface
- DATA_W, 8: register, ALU and data-bus width; legal range 8..32.
- REG_COUNT, 8: number of general registers; power of two, 2..256.
- ADDR_W, 8: data-memory address width; must be ≤ DATA_W.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- PC  out  32  address of the current instruction.
- IREAD  out  1  instruction fetch request.
- INSTRUCTION  in  32  fetched word; sampled when IREAD=1 and IBUSYWAIT=0.
- IBUSYWAIT  in  1  instruction memory stall.
- READ  out  1  data read request.
- WRITE  out  1  data write request.
- ADDRESS  out  ADDR_W  data address, taken from the low ADDR_W bits of the ALU result.
- WRITE_DATA  out  DATA_W  store data.
- READ_DATA  in  DATA_W  load data; sampled when READ=1 and BUSYWAIT=0.
- BUSYWAIT  in  1  data memory stall.

## Operation
- Fields:
  - opcode = [31:24]
  - dest / branch offset = [23:16]
  - src1 = [15:8]
  - src2 / imm = [7:0]
  - Register indices use the low log2(REG_COUNT) bits of each field.
- imm is sign-extended from 8 bits to DATA_W.
- Branch offset is sign-extended, shifted left by 2, and added to PC+4 (32-bit, wrap-around).
- Opcodes:
  - 0 loadi: rd=imm
  - 1 mov: rd=rs2
  - 2 add: rd=rs1+rs2
  - 3 sub: rd=rs1-rs2
  - 4 and: rd=rs1&rs2
  - 5 or: rd=rs1|rs2
  - 6 j
  - 7 beq: branch if rs1==rs2
  - 8 lwd: rd=M[rs2]
  - 9 lwi: rd=M[imm]
  - 10 swd: M[rs2]=rs1
  - 11 swi: M[imm]=rs1
  - 12 bne: branch if rs1!=rs2
  - 13..255: NOP
- Arithmetic wraps modulo 2^DATA_W; there are no flags.
- Register file: REG_COUNT×DATA_W, all zero on reset, written only in EXEC (ALU ops) or at MEM completion (loads).
- FSM states:
  - FETCH:
    - IREAD=1 and PC is driven.
    - Wait while IBUSYWAIT=1.
    - On a cycle with IBUSYWAIT=0, latch INSTRUCTION into IR and go to EXEC.
  - EXEC:
    - Decode IR and compute the ALU result.
    - Non-memory ops: write rd (if applicable), load PC with next PC (PC+4 or branch target), go to FETCH.
    - Memory ops: latch ADDRESS and WRITE_DATA, go to MEM.
  - MEM:
    - READ or WRITE=1 with ADDRESS and WRITE_DATA held stable.
    - Wait while BUSYWAIT=1.
    - On a cycle with BUSYWAIT=0, loads write READ_DATA to rd; then PC=PC+4 and go to FETCH.
- READ and WRITE are never both 1. IREAD is never 1 together with READ or WRITE.

## Timing
- Reset values:
  - state=FETCH, PC=0, IR=0, registers=0.
  - IREAD=0, READ=0, WRITE=0 while RESET=1.
  - ADDRESS=0, WRITE_DATA=0.
- First IREAD=1 appears in the first cycle after RESET falls.
- Latency with zero-wait memories:
  - ALU, jump and branch: 2 cycles.
  - Load and store: 3 cycles.
  - Each busywait cycle adds exactly one cycle.
- A register written in EXEC is visible to the next instruction's EXEC. There is no forwarding hazard because execution is serial.
- IBUSYWAIT is ignored outside FETCH; BUSYWAIT is ignored outside MEM.
- RESET during FETCH, EXEC or MEM:
  - Aborts the instruction with no register write.
  - READ, WRITE and IREAD drop in the reset cycle.
  - PC=0 at the next edge.
- Unknown opcode: PC advances by 4, with no register or memory side effects.
- Branch target wraps at 2^32. An offset of 0xFF branches to PC itself (PC+4-4).

## Test plan
- Reset then loadi r1,5; loadi r2,0xFE; add r3,r1,r2 with DATA_W=8 -> r3=0x03, PC=12 after 6 cycles, IREAD high one cycle per fetch.
- DATA_W=16: loadi r0,0x80; sub r1,r0,r0; beq offset 2 on r1==r1 -> r0=0xFF80, r1=0, PC jumps from 8 to 20; bne on equal regs -> PC+4.
- swi r1,0x10 with BUSYWAIT high 3 cycles, then lwi r4,0x10 -> WRITE held 4 cycles with ADDRESS=0x10, no READ overlap, r4 equals r1, PC advances only after BUSYWAIT falls.
- IBUSYWAIT held high 5 cycles in FETCH -> PC and registers frozen, IR unchanged, INSTRUCTION changes during the stall ignored, execution resumes in the cycle after IBUSYWAIT drops.
- RESET asserted mid-MEM of lwd -> READ drops in the reset cycle, rd unchanged (0), PC=0, and the next fetch is from address 0.
- Opcode 0xEE and j offset 0xFF -> NOP advances PC by 4; j self-loops with PC constant across 3 iterations.

Source files
------------

// File: rtl/cpu_multicycle.sv
`default_nettype none
// cpu_multicycle: FETCH/EXEC/MEM multi-cycle core with request/busywait
// handshakes to separate instruction and data memories.
module cpu_multicycle #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  output logic              IREAD,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IBUSYWAIT,
  output logic              READ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic [DATA_W-1:0] READ_DATA,
  input  logic              BUSYWAIT
);
  localparam int RIDX_W = $clog2(REG_COUNT);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_pc, w_pc_nxt;
  logic [31:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [REG_COUNT];
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [7:0]          w_opcode;
  logic [RIDX_W-1:0]   w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0]   w_imm, w_op1, w_op2, w_alu, w_reg_wdata;
  logic [31:0]         w_pc4, w_br_tgt;
  logic                w_is_load, w_is_store, w_is_mem, w_wr_alu, w_taken;
  logic                w_reg_we, w_mem_latch, w_ir_latch;
  logic                w_unused;

  assign w_opcode = r_ir[31:24];
  assign w_rd     = r_ir[16 +: RIDX_W];
  assign w_rs1    = r_ir[8 +: RIDX_W];
  assign w_rs2    = r_ir[0 +: RIDX_W];
  assign w_imm    = DATA_W'($signed(r_ir[7:0]));
  assign w_op1    = r_regs[w_rs1];
  assign w_op2    = r_regs[w_rs2];
  assign w_unused = ^r_ir;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = w_pc4 + {{22{r_ir[23]}}, r_ir[23:16], 2'b00};

  assign w_is_load  = (w_opcode == 8'd8)  || (w_opcode == 8'd9);
  assign w_is_store = (w_opcode == 8'd10) || (w_opcode == 8'd11);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_wr_alu   = (w_opcode <= 8'd5);
  assign w_taken    = (w_opcode == 8'd6)
                   || ((w_opcode == 8'd7)  && (w_op1 == w_op2))
                   || ((w_opcode == 8'd12) && (w_op1 != w_op2));

  // The ALU result doubles as the data address for memory ops.
  always_comb begin
    w_alu = '0;
    case (w_opcode)
      8'd0, 8'd9, 8'd11: w_alu = w_imm;
      8'd1, 8'd8, 8'd10: w_alu = w_op2;
      8'd2:              w_alu = w_op1 + w_op2;
      8'd3:              w_alu = w_op1 - w_op2;
      8'd4:              w_alu = w_op1 & w_op2;
      8'd5:              w_alu = w_op1 | w_op2;
      default:           w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_reg_we    = 1'b0;
    w_reg_wdata = w_alu;
    w_mem_latch = 1'b0;
    w_ir_latch  = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!IBUSYWAIT) begin
          w_ir_latch  = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_mem) begin
          w_mem_latch = 1'b1;
          w_state_nxt = S_MEM;
        end else begin
          w_reg_we    = w_wr_alu;
          w_pc_nxt    = w_taken ? w_br_tgt : w_pc4;
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (!BUSYWAIT) begin
          w_reg_we    = w_is_load;
          w_reg_wdata = READ_DATA;
          w_pc_nxt    = w_pc4;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_latch) r_ir <= INSTRUCTION;
      if (w_mem_latch) begin
        r_addr  <= w_alu[ADDR_W-1:0];
        r_wdata <= w_op1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_rd] <= w_reg_wdata;
    end
  end

  // Requests are gated by RESET so they drop within the reset cycle itself.
  assign PC         = r_pc;
  assign IREAD      = (r_state == S_FETCH) && !RESET;
  assign READ       = (r_state == S_MEM) && w_is_load && !RESET;
  assign WRITE      = (r_state == S_MEM) && w_is_store && !RESET;
  assign ADDRESS    = r_addr;
  assign WRITE_DATA = r_wdata;

endmodule
`default_nettype wire
